rf_scoreboard: RTL and testbench
================================

RF_SCOREBOARD -- requirements
Module: rf_scoreboard

Interface
REQ-001 SHALL provide parameter CNT_W, default 2, meaning width of each per-register outstanding-write counter (max count = 2^CNT_W - 1 = 3).
REQ-002 SHALL provide port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL provide port reset  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-004 SHALL provide port flush  input  1  pipeline flush; discards all outstanding-write tracking.
REQ-005 SHALL provide port issue_valid  input  1  decode presents an instruction for issue.
REQ-006 SHALL provide ports rs1, rs2, rd  input  5 each  source and destination register addresses of the decode instruction.
REQ-007 SHALL provide ports rs1_used, rs2_used, rd_used  input  1 each  operand or destination actually referenced.
REQ-008 SHALL provide port issue_ready  output  1  instruction may issue this cycle (combinational).
REQ-009 SHALL provide ports done_e_valid, done_w_valid  input  1 each  register write retiring from Execute and from Writeback.
REQ-010 SHALL provide ports done_e_rd, done_w_rd  input  5 each  destination register of each retiring write.
REQ-011 SHALL provide port busy_mask  output  32  bit r = 1 when register r has count > 0 (registered).
REQ-012 SHALL provide port outstanding  output  7  sum of all counters, range 0..93 (registered).
REQ-013 SHALL provide port err_underflow  output  1  sticky flag: a retire hit a register with count 0.

Function
REQ-014 SHALL hold one CNT_W-bit counter cnt[r] per register r = 1..31; cnt[0] SHALL be constant 0 and x0 never busy.
REQ-015 SHALL drive issue_ready = issue_valid AND NOT raw AND NOT waw_full, where raw = (rs1_used AND busy[rs1]) OR (rs2_used AND busy[rs2]).
REQ-016 SHALL assert waw_full when rd_used, rd != 0 and cnt[rd] = 3; issue_ready SHALL be low in that case.
REQ-017 SHALL increment cnt[rd] by 1 on a cycle with issue_ready = 1, rd_used = 1, rd != 0.
REQ-018 SHALL decrement cnt[done_e_rd] by 1 when done_e_valid, and cnt[done_w_rd] by 1 when done_w_valid, for nonzero addresses only.
REQ-019 SHALL apply increment and both decrements in the same cycle as net delta; same register hit by both retire ports decrements by 2.
REQ-020 SHALL, when a decrement would take a counter below 0, clamp it to 0 and set err_underflow to 1.
REQ-021 SHALL provide no same-cycle bypass: a retire in cycle N clears busy, and thus raw, from cycle N+1.
REQ-022 SHALL, on flush, zero all counters at the next edge; same-cycle issue and retires are ignored; err_underflow is unaffected.
REQ-023 SHALL update busy_mask and outstanding from next-state counters, so both are consistent with cnt in the cycle after each edge.

Reset
REQ-024 SHALL, on reset, clear all counters, busy_mask = 0, outstanding = 0 and err_underflow = 0; reset SHALL override flush, issue and retires.
REQ-025 SHALL hold issue_ready low while reset is high.

Structure
REQ-026 SHALL take the register-address type (5-bit), register count (32) and the outstanding width (7) from the shared core package.
REQ-027 SHALL instantiate one sub-module, sb_counter, per register: saturating up/down counter with inc, dec_e, dec_w, clear, and an underflow output.
REQ-028 SHALL implement raw/waw detection and the outstanding adder tree in the top module.

Verification
REQ-029 SHALL cover: issue rd=5, next cycle issue rs1=5 -> issue_ready=0; done_w_rd=5 -> issue_ready=1 one cycle later; busy_mask[5] returns to 0.
REQ-030 SHALL cover: three issues to rd=7, fourth to rd=7 -> issue_ready=0 (waw_full); one retire -> fourth issues; outstanding=3.
REQ-031 SHALL cover: cnt[9]=2, done_e and done_w both rd=9 with a same-cycle issue rd=9 -> cnt[9]=1, outstanding=1.
REQ-032 SHALL cover: done_w_rd=12 with cnt[12]=0 -> err_underflow=1 and stays set; cnt[12]=0.
REQ-033 SHALL cover: rd=0 issues and retires -> busy_mask=0, outstanding=0, err_underflow=0.
REQ-034 SHALL cover: flush with outstanding=5 and a same-cycle issue -> outstanding=0 next cycle; reset mid-stall -> all outputs 0 and issue_ready=0.

Source files
------------

// File: rtl/rf_scoreboard_pkg.sv
// ============================================================================
// Module      : rf_scoreboard_pkg
// Description : Shared core types and sizes for the register-file scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package rf_scoreboard_pkg;

    localparam int c_ADDR_W   = 5;
    localparam int c_NUM_REGS = 32;
    localparam int c_OUT_W    = 7;

    typedef logic [c_ADDR_W-1:0] reg_addr_t;

endpackage

`default_nettype wire

// File: rtl/rf_scoreboard_if.sv
// ============================================================================
// Module      : rf_scoreboard_if
// Description : Decode/issue, retire and status signals of the scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface rf_scoreboard_if;
    import rf_scoreboard_pkg::*;

    logic                     flush;
    logic                     issue_valid;
    reg_addr_t                rs1;
    reg_addr_t                rs2;
    reg_addr_t                rd;
    logic                     rs1_used;
    logic                     rs2_used;
    logic                     rd_used;
    logic                     issue_ready;
    logic                     done_e_valid;
    logic                     done_w_valid;
    reg_addr_t                done_e_rd;
    reg_addr_t                done_w_rd;
    logic [c_NUM_REGS-1:0]    busy_mask;
    logic [c_OUT_W-1:0]       outstanding;
    logic                     err_underflow;

    modport master (
        output flush, issue_valid, rs1, rs2, rd, rs1_used, rs2_used, rd_used,
        output done_e_valid, done_w_valid, done_e_rd, done_w_rd,
        input  issue_ready, busy_mask, outstanding, err_underflow
    );

    modport slave (
        input  flush, issue_valid, rs1, rs2, rd, rs1_used, rs2_used, rd_used,
        input  done_e_valid, done_w_valid, done_e_rd, done_w_rd,
        output issue_ready, busy_mask, outstanding, err_underflow
    );

endinterface

`default_nettype wire

// File: rtl/rf_scoreboard_sb_counter.sv
// ============================================================================
// Module      : sb_counter
// Description : Per-register saturating up/down outstanding-write counter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sb_counter #(
    parameter int CNT_W = 2
) (
    input  wire logic             clk,
    input  wire logic             reset,
    input  wire logic             clear,
    input  wire logic             inc,
    input  wire logic             dec_e,
    input  wire logic             dec_w,
    output logic [CNT_W-1:0]      cnt,
    output logic [CNT_W-1:0]      cnt_next,
    output logic                  underflow
);

    localparam logic [CNT_W:0] c_MAX = {1'b0, {CNT_W{1'b1}}};

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W:0]   w_up;
    logic [CNT_W:0]   w_down;
    logic [CNT_W:0]   w_diff;

    assign w_up   = {1'b0, r_cnt} + {{CNT_W{1'b0}}, inc};
    assign w_down = {{CNT_W{1'b0}}, dec_e} + {{CNT_W{1'b0}}, dec_w};

    // Flush discards same-cycle traffic, so it also masks underflow.
    always_comb begin
        underflow = 1'b0;
        w_diff    = '0;
        cnt_next  = r_cnt;
        if (clear) begin
            cnt_next = '0;
        end else if (w_down > w_up) begin
            underflow = 1'b1;
            cnt_next  = '0;
        end else begin
            w_diff = w_up - w_down;
            if (w_diff > c_MAX) begin
                cnt_next = '1;
            end else begin
                cnt_next = w_diff[CNT_W-1:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= cnt_next;
        end
    end

    assign cnt = r_cnt;

endmodule

`default_nettype wire

// File: rtl/rf_scoreboard.sv
// ============================================================================
// Module      : rf_scoreboard
// Description : Register scoreboard with RAW/WAW issue gating and retire tracking.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rf_scoreboard
    import rf_scoreboard_pkg::*;
#(
    parameter int CNT_W = 2
) (
    input  wire logic          clk,
    input  wire logic          reset,
    rf_scoreboard_if.slave     sb
);

    logic [CNT_W-1:0]      w_cnt      [c_NUM_REGS];
    logic [CNT_W-1:0]      w_cnt_next [c_NUM_REGS];
    logic [c_NUM_REGS-1:0] w_underflow;
    logic [c_NUM_REGS-1:0] w_busy_next;
    logic [c_OUT_W-1:0]    w_outstanding;
    logic                  w_raw;
    logic                  w_waw_full;
    logic                  w_issue_ready;
    logic                  w_wr;

    logic [c_NUM_REGS-1:0] r_busy_mask;
    logic [c_OUT_W-1:0]    r_outstanding;
    logic                  r_err;

    // Hazards use registered state only; a retire unblocks from the next cycle.
    assign w_raw = (sb.rs1_used & r_busy_mask[sb.rs1]) |
                   (sb.rs2_used & r_busy_mask[sb.rs2]);
    assign w_waw_full = sb.rd_used & (sb.rd != '0) &
                        (w_cnt[sb.rd] == {CNT_W{1'b1}});
    assign w_issue_ready = sb.issue_valid & ~reset & ~w_raw & ~w_waw_full;
    assign w_wr = w_issue_ready & sb.rd_used;

    generate
        for (genvar r = 0; r < c_NUM_REGS; r++) begin : g_reg
            if (r == 0) begin : g_zero
                assign w_cnt[r]       = '0;
                assign w_cnt_next[r]  = '0;
                assign w_underflow[r] = 1'b0;
            end else begin : g_cnt
                sb_counter #(
                    .CNT_W (CNT_W)
                ) u_cnt (
                    .clk       (clk),
                    .reset     (reset),
                    .clear     (sb.flush),
                    .inc       (w_wr & (sb.rd == reg_addr_t'(r))),
                    .dec_e     (sb.done_e_valid & (sb.done_e_rd == reg_addr_t'(r))),
                    .dec_w     (sb.done_w_valid & (sb.done_w_rd == reg_addr_t'(r))),
                    .cnt       (w_cnt[r]),
                    .cnt_next  (w_cnt_next[r]),
                    .underflow (w_underflow[r])
                );
            end
        end
    endgenerate

    always_comb begin
        w_outstanding = '0;
        w_busy_next   = '0;
        for (int i = 0; i < c_NUM_REGS; i++) begin
            w_outstanding  = w_outstanding + c_OUT_W'(w_cnt_next[i]);
            w_busy_next[i] = |w_cnt_next[i];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_busy_mask   <= '0;
            r_outstanding <= '0;
            r_err         <= 1'b0;
        end else begin
            r_busy_mask   <= w_busy_next;
            r_outstanding <= w_outstanding;
            r_err         <= r_err | (|w_underflow);
        end
    end

    assign sb.issue_ready   = w_issue_ready;
    assign sb.busy_mask     = r_busy_mask;
    assign sb.outstanding   = r_outstanding;
    assign sb.err_underflow = r_err;

endmodule

`default_nettype wire

// File: tb/tb_rf_scoreboard.sv
// ============================================================================
// Module      : tb_rf_scoreboard
// Description : Directed self-checking bench for rf_scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rf_scoreboard;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    rf_scoreboard_if sb ();

    rf_scoreboard #(
        .CNT_W (2)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .sb    (sb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        sb.flush        = 1'b0;
        sb.issue_valid  = 1'b0;
        sb.rs1          = '0;
        sb.rs2          = '0;
        sb.rd           = '0;
        sb.rs1_used     = 1'b0;
        sb.rs2_used     = 1'b0;
        sb.rd_used      = 1'b0;
        sb.done_e_valid = 1'b0;
        sb.done_w_valid = 1'b0;
        sb.done_e_rd    = '0;
        sb.done_w_rd    = '0;
    endtask

    task automatic set_issue(input logic [4:0] rd);
        idle();
        sb.issue_valid = 1'b1;
        sb.rd_used     = 1'b1;
        sb.rd          = rd;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks = 0;
        errors = 0;

        // Reset with an issue request pending
        idle();
        reset = 1'b1;
        sb.issue_valid = 1'b1;
        sb.rd_used     = 1'b1;
        sb.rd          = 5'd3;
        #2;
        check("ready_in_reset", 32'(sb.issue_ready), 32'd0);
        tick();
        tick();
        check("rst_busy", sb.busy_mask, 32'd0);
        check("rst_outstanding", 32'(sb.outstanding), 32'd0);
        check("rst_err", 32'(sb.err_underflow), 32'd0);
        reset = 1'b0;
        idle();

        // RAW on rd=5, cleared by writeback retire one cycle later
        set_issue(5'd5);
        #1;
        check("issue_rd5_ready", 32'(sb.issue_ready), 32'd1);
        tick();
        idle();
        sb.issue_valid  = 1'b1;
        sb.rs1          = 5'd5;
        sb.rs1_used     = 1'b1;
        sb.done_w_valid = 1'b1;
        sb.done_w_rd    = 5'd5;
        #1;
        check("raw_stall_ready", 32'(sb.issue_ready), 32'd0);
        check("raw_busy", sb.busy_mask, 32'h0000_0020);
        check("raw_outstanding", 32'(sb.outstanding), 32'd1);
        tick();
        idle();
        sb.issue_valid = 1'b1;
        sb.rs1         = 5'd5;
        sb.rs1_used    = 1'b1;
        #1;
        check("raw_clear_ready", 32'(sb.issue_ready), 32'd1);
        check("raw_clear_busy", sb.busy_mask, 32'd0);
        tick();

        // WAW saturation on rd=7
        for (int i = 0; i < 3; i++) begin
            set_issue(5'd7);
            #1;
            check("waw_fill_ready", 32'(sb.issue_ready), 32'd1);
            tick();
        end
        check("waw_outstanding3", 32'(sb.outstanding), 32'd3);
        check("waw_busy", sb.busy_mask, 32'h0000_0080);
        set_issue(5'd7);
        sb.done_e_valid = 1'b1;
        sb.done_e_rd    = 5'd7;
        #1;
        check("waw_full_ready", 32'(sb.issue_ready), 32'd0);
        tick();
        check("waw_after_retire", 32'(sb.outstanding), 32'd2);
        set_issue(5'd7);
        #1;
        check("waw_fourth_ready", 32'(sb.issue_ready), 32'd1);
        tick();
        check("waw_fourth_outstanding", 32'(sb.outstanding), 32'd3);
        idle();
        sb.done_e_valid = 1'b1;
        sb.done_e_rd    = 5'd7;
        sb.done_w_valid = 1'b1;
        sb.done_w_rd    = 5'd7;
        tick();
        check("waw_drain2", 32'(sb.outstanding), 32'd1);
        idle();
        sb.done_w_valid = 1'b1;
        sb.done_w_rd    = 5'd7;
        tick();
        check("waw_drained", 32'(sb.outstanding), 32'd0);

        // Net delta: +1 issue, -2 retires on rd=9
        set_issue(5'd9);
        tick();
        set_issue(5'd9);
        tick();
        check("net_pre", 32'(sb.outstanding), 32'd2);
        set_issue(5'd9);
        sb.done_e_valid = 1'b1;
        sb.done_e_rd    = 5'd9;
        sb.done_w_valid = 1'b1;
        sb.done_w_rd    = 5'd9;
        #1;
        check("net_ready", 32'(sb.issue_ready), 32'd1);
        tick();
        check("net_outstanding", 32'(sb.outstanding), 32'd1);
        check("net_busy", sb.busy_mask, 32'h0000_0200);
        idle();
        sb.done_w_valid = 1'b1;
        sb.done_w_rd    = 5'd9;
        tick();
        check("net_drained", 32'(sb.outstanding), 32'd0);

        // Underflow on idle register 12
        idle();
        sb.done_w_valid = 1'b1;
        sb.done_w_rd    = 5'd12;
        tick();
        check("uf_err", 32'(sb.err_underflow), 32'd1);
        check("uf_outstanding", 32'(sb.outstanding), 32'd0);
        idle();
        tick();
        check("uf_sticky", 32'(sb.err_underflow), 32'd1);
        check("uf_busy", sb.busy_mask, 32'd0);

        // x0 traffic is ignored
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("rst_clears_err", 32'(sb.err_underflow), 32'd0);
        set_issue(5'd0);
        sb.rs1          = 5'd0;
        sb.rs1_used     = 1'b1;
        sb.done_e_valid = 1'b1;
        sb.done_w_valid = 1'b1;
        #1;
        check("x0_ready", 32'(sb.issue_ready), 32'd1);
        tick();
        check("x0_busy", sb.busy_mask, 32'd0);
        check("x0_outstanding", 32'(sb.outstanding), 32'd0);
        check("x0_err", 32'(sb.err_underflow), 32'd0);

        // Flush discards tracking and same-cycle traffic
        for (int i = 1; i <= 5; i++) begin
            set_issue(5'(i));
            tick();
        end
        check("flush_pre_outstanding", 32'(sb.outstanding), 32'd5);
        check("flush_pre_busy", sb.busy_mask, 32'h0000_003E);
        set_issue(5'd6);
        sb.flush        = 1'b1;
        sb.done_w_valid = 1'b1;
        sb.done_w_rd    = 5'd1;
        sb.done_e_valid = 1'b1;
        sb.done_e_rd    = 5'd20;
        tick();
        check("flush_outstanding", 32'(sb.outstanding), 32'd0);
        check("flush_busy", sb.busy_mask, 32'd0);
        check("flush_err", 32'(sb.err_underflow), 32'd0);

        // Reset during a RAW stall
        idle();
        sb.done_e_valid = 1'b1;
        sb.done_e_rd    = 5'd13;
        tick();
        check("pre_rst_err", 32'(sb.err_underflow), 32'd1);
        set_issue(5'd8);
        tick();
        idle();
        sb.issue_valid = 1'b1;
        sb.rs2         = 5'd8;
        sb.rs2_used    = 1'b1;
        #1;
        check("stall_ready", 32'(sb.issue_ready), 32'd0);
        check("stall_busy", sb.busy_mask, 32'h0000_0100);
        reset = 1'b1;
        tick();
        check("midrst_ready", 32'(sb.issue_ready), 32'd0);
        check("midrst_busy", sb.busy_mask, 32'd0);
        check("midrst_outstanding", 32'(sb.outstanding), 32'd0);
        check("midrst_err", 32'(sb.err_underflow), 32'd0);
        reset = 1'b0;
        idle();
        #1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
